// File: rtl/sfifo_pkg.sv
// sfifo_pkg: shared constants and helpers for the synchronous FIFO slice.
// Read latency derives from the memory output-register option; default
// almost-full/almost-empty thresholds live here so wrapper and controller agree.
package sfifo_pkg;

    localparam int unsigned DEF_NBIT_A       = 4;
    localparam int unsigned DEF_NBIT_D       = 8;
    // almost_full default sits this many entries below depth
    localparam int unsigned DEF_AFULL_MARGIN = 2;
    localparam int unsigned DEF_AEMPTY_TH    = 2;

    // Cycles from an accepted read to valid memory data.
    function automatic int unsigned rd_latency(input logic output_reg_en);
        return output_reg_en ? 2 : 1;
    endfunction

endpackage

// File: rtl/afifomem.sv
// afifomem: simple dual-port RAM, write on wclk, read on rclk.
// Optional second output register adds one cycle of read latency.
module afifomem #(
    parameter int unsigned p_nbit_a        = 4,
    parameter int unsigned p_nbit_d        = 8,
    parameter logic        p_output_reg_en = 1'b1
) (
    input  logic                wclk,
    input  logic                wen,
    input  logic [p_nbit_a-1:0] waddr,
    input  logic [p_nbit_d-1:0] wdata,
    input  logic                rclk,
    input  logic                ren,
    input  logic [p_nbit_a-1:0] raddr,
    output logic [p_nbit_d-1:0] rdata
);

    logic [p_nbit_d-1:0] r_mem [2**p_nbit_a];
    logic [p_nbit_d-1:0] r_rdata;

    // Write port
    always_ff @(posedge wclk) begin
        if (wen) r_mem[waddr] <= wdata;
    end

    // Read port, first pipeline stage
    always_ff @(posedge rclk) begin
        if (ren) r_rdata <= r_mem[raddr];
    end

    generate
        if (p_output_reg_en) begin : g_oreg
            logic [p_nbit_d-1:0] r_rdata_q;
            // Optional output register
            always_ff @(posedge rclk) begin
                r_rdata_q <= r_rdata;
            end
            // Drive data from the output register
            always_comb begin
                rdata = r_rdata_q;
            end
        end else begin : g_noreg
            // Drive data straight from the read stage
            always_comb begin
                rdata = r_rdata;
            end
        end
    endgenerate

endmodule

// File: rtl/sfifo.sv
// sfifo: controller plus memory; data passes straight through afifomem.
// Optional macro SFIFO_CTRL_ALMOST_EN exposes almost_full/almost_empty.
module sfifo
    import sfifo_pkg::*;
#(
    parameter int unsigned p_nbit_a        = DEF_NBIT_A,
    parameter int unsigned p_nbit_d        = DEF_NBIT_D,
    parameter logic        p_output_reg_en = 1'b1,
    parameter int unsigned p_afull_th      = 2**p_nbit_a - DEF_AFULL_MARGIN,
    parameter int unsigned p_aempty_th     = DEF_AEMPTY_TH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [p_nbit_d-1:0] wdata,
    output logic [p_nbit_d-1:0] rdata,
    output logic                rvalid,
    output logic                full,
    output logic                empty,
    output logic [p_nbit_a:0]   count,
    output logic                overflow,
    output logic                underflow
`ifdef SFIFO_CTRL_ALMOST_EN
    ,
    output logic                almost_full,
    output logic                almost_empty
`endif
);

    logic                w_mem_wr;
    logic                w_mem_rd;
    logic [p_nbit_a-1:0] w_mem_waddr;
    logic [p_nbit_a-1:0] w_mem_raddr;

    sfifo_ctrl #(
        .p_nbit_a        (p_nbit_a),
        .p_output_reg_en (p_output_reg_en),
        .p_afull_th      (p_afull_th),
        .p_aempty_th     (p_aempty_th)
    ) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .pop          (pop),
        .flush        (flush),
        .mem_wr       (w_mem_wr),
        .mem_waddr    (w_mem_waddr),
        .mem_rd       (w_mem_rd),
        .mem_raddr    (w_mem_raddr),
        .rvalid       (rvalid),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef SFIFO_CTRL_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    afifomem #(
        .p_nbit_a        (p_nbit_a),
        .p_nbit_d        (p_nbit_d),
        .p_output_reg_en (p_output_reg_en)
    ) u_mem (
        .wclk  (clk),
        .wen   (w_mem_wr),
        .waddr (w_mem_waddr),
        .wdata (wdata),
        .rclk  (clk),
        .ren   (w_mem_rd),
        .raddr (w_mem_raddr),
        .rdata (rdata)
    );

endmodule

// File: rtl/sfifo_ctrl.sv
// sfifo_ctrl: pointer/occupancy controller for a single-clock FIFO.
// Optional macro SFIFO_CTRL_ALMOST_EN adds almost_full/almost_empty ports.
// Status flags derive only from the count register, never from push/pop.
module sfifo_ctrl
    import sfifo_pkg::*;
#(
    parameter int unsigned p_nbit_a        = DEF_NBIT_A,
    parameter logic        p_output_reg_en = 1'b1,
    parameter int unsigned p_afull_th      = 2**p_nbit_a - DEF_AFULL_MARGIN,
    parameter int unsigned p_aempty_th     = DEF_AEMPTY_TH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    output logic                mem_wr,
    output logic [p_nbit_a-1:0] mem_waddr,
    output logic                mem_rd,
    output logic [p_nbit_a-1:0] mem_raddr,
    output logic                rvalid,
    output logic                full,
    output logic                empty,
    output logic [p_nbit_a:0]   count,
    output logic                overflow,
    output logic                underflow
`ifdef SFIFO_CTRL_ALMOST_EN
    ,
    output logic                almost_full,
    output logic                almost_empty
`endif
);

    localparam int unsigned       LP_LAT     = rd_latency(p_output_reg_en);
    localparam logic [p_nbit_a:0] LP_DEPTH_C = {1'b1, {p_nbit_a{1'b0}}};

    logic [p_nbit_a-1:0] r_wptr;
    logic [p_nbit_a-1:0] r_rptr;
    logic [p_nbit_a:0]   r_count;
    logic [LP_LAT-1:0]   r_rv_pipe;
    logic                r_ovf;
    logic                r_unf;
    logic                w_full;
    logic                w_empty;
    logic                w_wr_acc;
    logic                w_rd_acc;

    // Status from registered count, then transfer acceptance (flush blocks both)
    always_comb begin
        w_full   = (r_count == LP_DEPTH_C);
        w_empty  = (r_count == '0);
        w_wr_acc = push & ~w_full & ~flush;
        w_rd_acc = pop & ~w_empty & ~flush;
    end

    // Pointers and occupancy; pointers wrap naturally at depth
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + p_nbit_a'(1);
            if (w_rd_acc) r_rptr <= r_rptr + p_nbit_a'(1);
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + (p_nbit_a+1)'(1);
                2'b01:   r_count <= r_count - (p_nbit_a+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; only reset or flush clears them
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (push && w_full)  r_ovf <= 1'b1;
            if (pop  && w_empty) r_unf <= 1'b1;
        end
    end

    // Read-valid delay line matching memory latency; cleared so in-flight beats vanish
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_rv_pipe <= '0;
        end else begin
            r_rv_pipe[0] <= w_rd_acc;
            for (int unsigned i = 1; i < LP_LAT; i++) begin
                r_rv_pipe[i] <= r_rv_pipe[i-1];
            end
        end
    end

    // Output mapping
    always_comb begin
        mem_wr    = w_wr_acc;
        mem_waddr = r_wptr;
        mem_rd    = w_rd_acc;
        mem_raddr = r_rptr;
        rvalid    = r_rv_pipe[LP_LAT-1];
        full      = w_full;
        empty     = w_empty;
        count     = r_count;
        overflow  = r_ovf;
        underflow = r_unf;
    end

`ifdef SFIFO_CTRL_ALMOST_EN
    localparam logic [p_nbit_a:0] LP_AFULL_TH  = p_afull_th[p_nbit_a:0];
    localparam logic [p_nbit_a:0] LP_AEMPTY_TH = p_aempty_th[p_nbit_a:0];

    // Threshold compares on registered count
    always_comb begin
        almost_full  = (r_count >= LP_AFULL_TH);
        almost_empty = (r_count <= LP_AEMPTY_TH);
    end
`endif

endmodule

// File: tb/tb_sfifo_ctrl.sv
// tb_sfifo_ctrl: table-driven check of sfifo_ctrl (depth 4, latency 2) plus a
// data-path check of the sfifo wrapper at latency 1.
// Honours SFIFO_CTRL_ALMOST_EN when defined.
module tb_sfifo_ctrl;

    localparam int unsigned NA  = 2;
    localparam int unsigned D   = 4;
    localparam int unsigned LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_n, push, pop, flush;
    logic          mem_wr, mem_rd, rvalid, full, empty, overflow, underflow;
    logic [NA-1:0] mem_waddr, mem_raddr;
    logic [NA:0]   count;
`ifdef SFIFO_CTRL_ALMOST_EN
    logic          almost_full, almost_empty, f_afull, f_aempty;
`endif

    logic          f_push, f_pop, f_flush;
    logic [7:0]    f_wdata, f_rdata;
    logic          f_rvalid, f_full, f_empty, f_ovf, f_unf;
    logic [NA:0]   f_count;

    sfifo_ctrl #(
        .p_nbit_a        (NA),
        .p_output_reg_en (1'b1)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .pop          (pop),
        .flush        (flush),
        .mem_wr       (mem_wr),
        .mem_waddr    (mem_waddr),
        .mem_rd       (mem_rd),
        .mem_raddr    (mem_raddr),
        .rvalid       (rvalid),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef SFIFO_CTRL_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    sfifo #(
        .p_nbit_a        (NA),
        .p_nbit_d        (8),
        .p_output_reg_en (1'b0)
    ) u_fifo0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (f_push),
        .pop          (f_pop),
        .flush        (f_flush),
        .wdata        (f_wdata),
        .rdata        (f_rdata),
        .rvalid       (f_rvalid),
        .full         (f_full),
        .empty        (f_empty),
        .count        (f_count),
        .overflow     (f_ovf),
        .underflow    (f_unf)
`ifdef SFIFO_CTRL_ALMOST_EN
        ,
        .almost_full  (f_afull),
        .almost_empty (f_aempty)
`endif
    );

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned n_rv_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic pu, po, fl, rn;
        int   ewr, erd, ewa, era, ecnt, eovf, eunf;
    } vec_t;

    function automatic vec_t v(input logic pu, po, fl, rn,
                               input int ewr, erd, ewa, era, ecnt, eovf, eunf);
        vec_t r;
        r.pu = pu; r.po = po; r.fl = fl; r.rn = rn;
        r.ewr = ewr; r.erd = erd; r.ewa = ewa; r.era = era;
        r.ecnt = ecnt; r.eovf = eovf; r.eunf = eunf;
        return r;
    endfunction

    // Scoreboard: cycle numbers at which rvalid is due.
    int unsigned sb_due[$];

    // One cycle: drive, check combinational outputs and rvalid, clock, check state.
    // ewa/era < 0 means the address is not yet defined.
    task automatic step(input vec_t t, input string tag);
        bit exp_rv;
        @(negedge clk);
        push = t.pu; pop = t.po; flush = t.fl; rst_n = t.rn;
        #1;
        chk({tag, ".mem_wr"}, mem_wr, t.ewr);
        chk({tag, ".mem_rd"}, mem_rd, t.erd);
        if (t.ewa >= 0) chk({tag, ".mem_waddr"}, mem_waddr, t.ewa);
        if (t.era >= 0) chk({tag, ".mem_raddr"}, mem_raddr, t.era);
        exp_rv = (sb_due.size() > 0) && (sb_due[0] == cyc);
        if (exp_rv) void'(sb_due.pop_front());
        chk({tag, ".rvalid"}, rvalid, exp_rv);
        if (rvalid) n_rv_seen++;
        if (t.erd != 0) sb_due.push_back(cyc + LAT);
        if (t.fl || !t.rn) sb_due.delete();
        @(posedge clk);
        #1;
        chk({tag, ".count"}, count, t.ecnt);
        chk({tag, ".full"}, full, (t.ecnt == D));
        chk({tag, ".empty"}, empty, (t.ecnt == 0));
        chk({tag, ".overflow"}, overflow, t.eovf);
        chk({tag, ".underflow"}, underflow, t.eunf);
`ifdef SFIFO_CTRL_ALMOST_EN
        chk({tag, ".almost_full"}, almost_full, (t.ecnt >= D - 2));
        chk({tag, ".almost_empty"}, almost_empty, (t.ecnt <= 2));
`endif
    endtask

    // Data scoreboard for the latency-1 wrapper.
    typedef struct {
        int unsigned due;
        logic [7:0]  data;
    } fsb_t;
    fsb_t       fsb[$];
    logic [7:0] fmem[$];

    task automatic fstep(input logic pu, po, input logic [7:0] wd, input string tag);
        bit   exp_rv;
        bit   racc, wacc;
        fsb_t e;
        @(negedge clk);
        f_push = pu; f_pop = po; f_wdata = wd;
        #1;
        exp_rv = (fsb.size() > 0) && (fsb[0].due == cyc);
        chk({tag, ".rvalid"}, f_rvalid, exp_rv);
        if (exp_rv) begin
            chk({tag, ".rdata"}, f_rdata, fsb[0].data);
            void'(fsb.pop_front());
        end
        racc = po && (fmem.size() > 0);
        wacc = pu && (fmem.size() < D);
        if (racc) begin
            e.due  = cyc + 1;
            e.data = fmem.pop_front();
            fsb.push_back(e);
        end
        if (wacc) fmem.push_back(wd);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0;
        f_push = 1'b0; f_pop = 1'b0; f_flush = 1'b0; f_wdata = '0;

        //                pu po fl rn  wr rd wa  ra  cnt ovf unf
        tbl.push_back(v(0, 0, 0, 0,  0, 0, -1, -1, 0, 0, 0)); // reset
        tbl.push_back(v(0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0)); // reset state
        tbl.push_back(v(1, 0, 0, 1,  1, 0, 0,  0,  1, 0, 0)); // fill
        tbl.push_back(v(1, 0, 0, 1,  1, 0, 1,  0,  2, 0, 0));
        tbl.push_back(v(1, 0, 0, 1,  1, 0, 2,  0,  3, 0, 0));
        tbl.push_back(v(1, 0, 0, 1,  1, 0, 3,  0,  4, 0, 0)); // full
        tbl.push_back(v(1, 1, 0, 1,  0, 1, 0,  0,  3, 1, 0)); // push rejected when full
        tbl.push_back(v(0, 0, 0, 1,  0, 0, 0,  1,  3, 1, 0));
        tbl.push_back(v(0, 0, 0, 1,  0, 0, 0,  1,  3, 1, 0)); // rvalid due here
        tbl.push_back(v(0, 0, 1, 1,  0, 0, 0,  1,  0, 0, 0)); // flush clears overflow
        tbl.push_back(v(0, 1, 0, 1,  0, 0, 0,  0,  0, 0, 1)); // pop while empty
        tbl.push_back(v(1, 1, 0, 1,  1, 0, 0,  0,  1, 0, 1)); // pop rejected when empty
        tbl.push_back(v(1, 1, 1, 1,  0, 0, 1,  0,  0, 0, 0)); // flush beats push/pop
        tbl.push_back(v(0, 0, 0, 1,  0, 0, 0,  0,  0, 0, 0));

        foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

        // Steady streaming at count 2 with pointer wrap
        step(v(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0), "s41.fill0");
        step(v(1, 0, 0, 1, 1, 0, 1, 0, 2, 0, 0), "s41.fill1");
        n_rv_seen = 0;
        for (int k = 0; k < 6; k++)
            step(v(1, 1, 0, 1, 1, 1, (2 + k) % 4, k % 4, 2, 0, 0), $sformatf("s41.pp%0d", k));
        step(v(0, 0, 0, 1, 0, 0, 0, 2, 2, 0, 0), "s41.idle0");
        step(v(0, 0, 0, 1, 0, 0, 0, 2, 2, 0, 0), "s41.idle1");
        chk("s41.pulses", n_rv_seen, 6);

        // Pop in flight, then flush
        step(v(0, 1, 0, 1, 0, 1, 0, 2, 1, 0, 0), "s44f.pop");
        step(v(0, 0, 1, 1, 0, 0, 0, 3, 0, 0, 0), "s44f.flush");
        n_rv_seen = 0;
        for (int k = 0; k < 3; k++)
            step(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), $sformatf("s44f.idle%0d", k));
        chk("s44f.no_rvalid", n_rv_seen, 0);

        // Pop in flight, then reset
        step(v(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0), "s44r.push");
        step(v(0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0), "s44r.pop");
        step(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "s44r.reset");
        n_rv_seen = 0;
        for (int k = 0; k < 3; k++)
            step(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), $sformatf("s44r.idle%0d", k));
        chk("s44r.no_rvalid", n_rv_seen, 0);

        // Latency-1 data path through the wrapper
        fstep(1'b1, 1'b0, 8'hA5, "s43.push");
        fstep(1'b0, 1'b1, 8'h00, "s43.pop");
        fstep(1'b0, 1'b0, 8'h00, "s43.read");
        fstep(1'b1, 1'b0, 8'h3C, "s43.push2");
        fstep(1'b1, 1'b1, 8'hC3, "s43.pp");
        fstep(1'b0, 1'b1, 8'h00, "s43.pop2");
        fstep(1'b0, 1'b0, 8'h00, "s43.read2");
        fstep(1'b0, 1'b0, 8'h00, "s43.idle");
        chk("s43.count", f_count, 0);
        chk("s43.empty", f_empty, 1);
        chk("s43.sb_drained", fsb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sfifo_ctrl.md
SFIFO_CTRL -- requirements
Module: sfifo_ctrl

Interface
REQ-001 Parameter p_nbit_a, default 4: memory address width; depth D = 2**p_nbit_a.
REQ-002 Parameter p_output_reg_en, default 1'b1: 1 = memory output registered, so read latency L = 2; 0 = read latency L = 1.
REQ-003 Parameter p_afull_th, default 2**p_nbit_a-2: almost_full threshold; used only with SFIFO_CTRL_ALMOST_EN.
REQ-004 Parameter p_aempty_th, default 2: almost_empty threshold; used only with SFIFO_CTRL_ALMOST_EN.
REQ-005 Port clk  in  1: single clock, rising edge; shared with the memory wclk and rclk.
REQ-006 Port rst_n  in  1: reset, synchronous, active-low.
REQ-007 Port push  in  1: write request from the producer.
REQ-008 Port pop  in  1: read request from the consumer.
REQ-009 Port flush  in  1: synchronous clear of FIFO state.
REQ-010 Port mem_wr  out  1: memory write enable.
REQ-011 Port mem_waddr  out  p_nbit_a: memory write address.
REQ-012 Port mem_rd  out  1: memory read enable.
REQ-013 Port mem_raddr  out  p_nbit_a: memory read address.
REQ-014 Port rvalid  out  1: memory rdata is valid this cycle.
REQ-015 Port full  out  1: count == D.
REQ-016 Port empty  out  1: count == 0.
REQ-017 Port count  out  p_nbit_a+1: current occupancy, 0..D.
REQ-018 Port overflow  out  1: sticky; set when push arrives while full.
REQ-019 Port underflow  out  1: sticky; set when pop arrives while empty.
REQ-020 Port almost_full  out  1: count >= p_afull_th; present only with SFIFO_CTRL_ALMOST_EN.
REQ-021 Port almost_empty  out  1: count <= p_aempty_th; present only with SFIFO_CTRL_ALMOST_EN.

Function
REQ-022 Write acceptance SHALL be wr_acc = push & ~full & ~flush; mem_wr = wr_acc (combinational); mem_waddr = wptr.
REQ-023 Read acceptance SHALL be rd_acc = pop & ~empty & ~flush; mem_rd = rd_acc (combinational); mem_raddr = rptr.
REQ-024 wptr SHALL increment by 1 on wr_acc, modulo D; rptr SHALL increment by 1 on rd_acc, modulo D; wrap from D-1 to 0 SHALL be silent.
REQ-025 count SHALL update as follows: +1 on wr_acc only; -1 on rd_acc only; unchanged when both fire or neither fires.
REQ-026 Push and pop in the same cycle SHALL both be accepted when 0 < count < D.
REQ-027 When full, push SHALL be rejected even if a pop occurs in the same cycle; when empty, pop SHALL be rejected even if a push occurs in the same cycle.
REQ-028 rvalid SHALL assert exactly L cycles after each rd_acc, implemented as an L-deep shift register.
REQ-029 A push accepted in cycle t SHALL be readable by a pop in cycle t+1, with no mixed-port read-during-write hazard.
REQ-030 overflow SHALL set on push & full & ~flush; underflow SHALL set on pop & empty & ~flush; both SHALL clear only by reset or flush.
REQ-031 flush SHALL take priority over push and pop: next cycle wptr = rptr = count = 0, rvalid pipeline cleared, sticky flags cleared.
REQ-032 full, empty, almost_full and almost_empty SHALL be registered-derived from count, with no combinational path from push or pop.

Reset
REQ-033 When rst_n = 0 at a clk edge: wptr = rptr = count = 0, rvalid pipeline = 0, overflow = underflow = 0.
REQ-034 Outputs after reset: empty = 1, full = 0, almost_empty = 1, almost_full = 0, rvalid = 0, mem_wr = mem_rd = 0.
REQ-035 Reset asserted mid-burst SHALL discard in-flight rvalid beats; no rvalid is asserted in the cycle after reset.

Configuration
REQ-036 Macro SFIFO_CTRL_ALMOST_EN: when defined, the almost_full and almost_empty ports and their compare logic exist; when undefined, the ports and logic are absent and all other behaviour is unchanged.

Structure
REQ-037 Package sfifo_pkg SHALL hold the read-latency function L(p_output_reg_en) and the default-threshold constants.
REQ-038 sfifo_ctrl SHALL have no sub-module; a wrapper sfifo SHALL instantiate sfifo_ctrl alongside afifomem, with data paths connected directly.

Verification (p_nbit_a = 2, D = 4, p_output_reg_en = 1 unless stated)
REQ-039 Reset, then 4 pushes -> count 0→4, full = 1 after the 4th push, mem_waddr sequence 0, 1, 2, 3, overflow = 0.
REQ-040 Full, then push + pop in the same cycle -> push rejected, overflow = 1, count = 3, mem_raddr = 0; rvalid asserts 2 cycles later.
REQ-041 count = 2, then 6 cycles of simultaneous push + pop -> count stays 2, both pointers wrap 3→0, six rvalid pulses each lagging its pop by 2 cycles.
REQ-042 Empty, then pop -> mem_rd = 0, underflow = 1, rvalid stays 0; a following flush clears underflow.
REQ-043 p_output_reg_en = 0: push at cycle t, pop at t+1 -> rvalid at t+2, data equals the pushed word.
REQ-044 Pop in flight, then flush (or rst_n = 0) the next cycle -> rvalid never asserts, count = 0, empty = 1; with SFIFO_CTRL_ALMOST_EN, almost_empty = 1.
